// File: rtl/branch_predict_unit.sv
// branch_predict_unit: RISC-V branch condition resolver with a direct-mapped saturating-counter predictor and statistics
module branch_predict_unit #(
  parameter int XLEN      = 32,
  parameter int BHT_DEPTH = 64,
  parameter int CTR_W     = 2,
  parameter int CNT_W     = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             pred_valid_i,
  input  logic [XLEN-1:0]  pred_pc_i,
  output logic             pred_taken_o,
  output logic             pred_taken_valid_o,
  input  logic             res_valid_i,
  input  logic [6:0]       res_opcode_i,
  input  logic [2:0]       res_funct3_i,
  input  logic [XLEN-1:0]  res_a_i,
  input  logic [XLEN-1:0]  res_b_i,
  input  logic [XLEN-1:0]  res_pc_i,
  input  logic             res_pred_taken_i,
  output logic             res_done_o,
  output logic             diverge_o,
  output logic             mispredict_o,
  input  logic             stat_clear_i,
  output logic [CNT_W-1:0] branch_count_o,
  output logic [CNT_W-1:0] mispredict_count_o
);
  localparam int IDX_W = $clog2(BHT_DEPTH);
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [CTR_W-1:0] CTR_RST = CTR_W'((2 ** (CTR_W - 1)) - 1);

  logic [CTR_W-1:0] bht_q [BHT_DEPTH];
  logic [IDX_W-1:0] pred_idx, res_idx;
  logic             is_br, eq, lt, ltu, taken, mispredict_d;
  logic [CTR_W-1:0] ctr_cur, ctr_d;
  logic [CNT_W-1:0] br_cnt_q, br_cnt_d, mp_cnt_q, mp_cnt_d;
  logic             pred_taken_q, pred_vld_q, res_done_q, diverge_q, mispredict_q;
  logic             unused_pc;

  assign pred_idx  = pred_pc_i[IDX_W+1:2];
  assign res_idx   = res_pc_i[IDX_W+1:2];
  assign unused_pc = ^{pred_pc_i[XLEN-1:IDX_W+2], pred_pc_i[1:0], res_pc_i[XLEN-1:IDX_W+2], res_pc_i[1:0]};

  // Condition evaluation, counter training value and saturating statistics next state
  always_comb begin
    is_br        = res_valid_i && res_opcode_i == OPC_BRANCH && res_funct3_i[2:1] != 2'b01;
    eq           = res_a_i == res_b_i;
    lt           = $signed(res_a_i) < $signed(res_b_i);
    ltu          = res_a_i < res_b_i;
    taken        = is_br && ((res_funct3_i[2] ? (res_funct3_i[1] ? ltu : lt) : eq) ^ res_funct3_i[0]);
    mispredict_d = is_br && (taken != res_pred_taken_i);
    ctr_cur      = bht_q[res_idx];
    ctr_d        = taken ? ((&ctr_cur) ? ctr_cur : ctr_cur + 1'b1)
                         : ((|ctr_cur) ? ctr_cur - 1'b1 : ctr_cur);
    br_cnt_d     = stat_clear_i ? '0 : (is_br && !(&br_cnt_q)) ? br_cnt_q + 1'b1 : br_cnt_q;
    mp_cnt_d     = stat_clear_i ? '0 : (mispredict_d && !(&mp_cnt_q)) ? mp_cnt_q + 1'b1 : mp_cnt_q;
  end

  // Counter table; lookups read the old value when a same-index update lands this cycle
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < BHT_DEPTH; i++) bht_q[i] <= CTR_RST;
    end else if (is_br) begin
      bht_q[res_idx] <= ctr_d;
    end
  end

  // Registered prediction, resolve pulses and statistics
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pred_taken_q <= 1'b0;
      pred_vld_q   <= 1'b0;
      res_done_q   <= 1'b0;
      diverge_q    <= 1'b0;
      mispredict_q <= 1'b0;
      br_cnt_q     <= '0;
      mp_cnt_q     <= '0;
    end else begin
      pred_taken_q <= pred_valid_i && bht_q[pred_idx][CTR_W-1];
      pred_vld_q   <= pred_valid_i;
      res_done_q   <= res_valid_i;
      diverge_q    <= taken;
      mispredict_q <= mispredict_d;
      br_cnt_q     <= br_cnt_d;
      mp_cnt_q     <= mp_cnt_d;
    end
  end

  assign pred_taken_o       = pred_taken_q;
  assign pred_taken_valid_o = pred_vld_q;
  assign res_done_o         = res_done_q;
  assign diverge_o          = diverge_q;
  assign mispredict_o       = mispredict_q;
  assign branch_count_o     = br_cnt_q;
  assign mispredict_count_o = mp_cnt_q;
endmodule

// File: tb/tb_branch_predict_unit.sv
// tb_branch_predict_unit: directed checks of resolution, prediction training, hazards and statistics
module tb_branch_predict_unit;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_ARI_RTYPE = 7'b0110011;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        pred_valid_i = 1'b0;
  logic [31:0] pred_pc_i = '0;
  logic        pred_taken_o, pred_taken_valid_o;
  logic        res_valid_i = 1'b0;
  logic [6:0]  res_opcode_i = '0;
  logic [2:0]  res_funct3_i = '0;
  logic [31:0] res_a_i = '0, res_b_i = '0, res_pc_i = '0;
  logic        res_pred_taken_i = 1'b0;
  logic        res_done_o, diverge_o, mispredict_o;
  logic        stat_clear_i = 1'b0;
  logic [3:0]  branch_count_o, mispredict_count_o;

  int checks = 0;
  int errors = 0;

  branch_predict_unit #(.XLEN(32), .BHT_DEPTH(64), .CTR_W(2), .CNT_W(4)) dut (
    .clk(clk), .rst_n(rst_n),
    .pred_valid_i(pred_valid_i), .pred_pc_i(pred_pc_i),
    .pred_taken_o(pred_taken_o), .pred_taken_valid_o(pred_taken_valid_o),
    .res_valid_i(res_valid_i), .res_opcode_i(res_opcode_i), .res_funct3_i(res_funct3_i),
    .res_a_i(res_a_i), .res_b_i(res_b_i), .res_pc_i(res_pc_i), .res_pred_taken_i(res_pred_taken_i),
    .res_done_o(res_done_o), .diverge_o(diverge_o), .mispredict_o(mispredict_o),
    .stat_clear_i(stat_clear_i),
    .branch_count_o(branch_count_o), .mispredict_count_o(mispredict_count_o)
  );

  always #5 clk = ~clk;

  task automatic cycle();
    @(posedge clk);
    #1;
    pred_valid_i = 1'b0;
    res_valid_i  = 1'b0;
    stat_clear_i = 1'b0;
  endtask

  task automatic drive_res(input logic [6:0] opc, input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b,
                           input logic [31:0] pc, input logic pt);
    res_valid_i = 1'b1; res_opcode_i = opc; res_funct3_i = f3;
    res_a_i = a; res_b_i = b; res_pc_i = pc; res_pred_taken_i = pt;
  endtask

  task automatic lookup(input logic [31:0] pc);
    pred_valid_i = 1'b1; pred_pc_i = pc;
  endtask

  task automatic test_reset();
    drive_res(OPC_BRANCH, 3'b000, 32'd1, 32'd1, 32'h100, 1'b0);
    cycle();
    checks++; if (res_done_o !== 1'b1) begin errors++; $display("FAIL pre_reset_done got=%0h exp=1", res_done_o); end
    checks++; if (branch_count_o !== 4'd1) begin errors++; $display("FAIL pre_reset_bcount got=%0d exp=1", branch_count_o); end
    drive_res(OPC_BRANCH, 3'b000, 32'd1, 32'd1, 32'h104, 1'b0);
    lookup(32'h100);
    rst_n = 1'b0;
    #1;
    checks++; if ({res_done_o, diverge_o, mispredict_o, pred_taken_valid_o} !== 4'b0) begin errors++; $display("FAIL async_reset_outs got=%b exp=0000", {res_done_o, diverge_o, mispredict_o, pred_taken_valid_o}); end
    checks++; if ({branch_count_o, mispredict_count_o} !== 8'h00) begin errors++; $display("FAIL async_reset_counts got=%h exp=00", {branch_count_o, mispredict_count_o}); end
    @(posedge clk);
    #2;
    res_valid_i = 1'b0; pred_valid_i = 1'b0;
    rst_n = 1'b1;
    cycle();
    checks++; if (res_done_o !== 1'b0 || pred_taken_valid_o !== 1'b0) begin errors++; $display("FAIL discarded_req got=%b%b exp=00", res_done_o, pred_taken_valid_o); end
    lookup(32'h100);
    cycle();
    checks++; if (pred_taken_o !== 1'b0 || pred_taken_valid_o !== 1'b1) begin errors++; $display("FAIL reset_lookup got=%b%b exp=01", pred_taken_o, pred_taken_valid_o); end
    checks++; if ({branch_count_o, mispredict_count_o} !== 8'h00) begin errors++; $display("FAIL reset_counts got=%h exp=00", {branch_count_o, mispredict_count_o}); end
  endtask

  task automatic test_conditions();
    logic [31:0] av [8] = '{32'hf000ffff, 32'hf000ffff, 32'hf000ffff, 32'hf000ffff, 32'h0, 32'h0, 32'h0, 32'h0};
    logic [31:0] bv [8] = '{32'hf, 32'hf, 32'hf, 32'hf, 32'h0, 32'h0, 32'h0, 32'h0};
    logic [2:0]  fv [8] = '{3'b100, 3'b110, 3'b101, 3'b111, 3'b101, 3'b100, 3'b000, 3'b001};
    logic        ev [8] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0};
    logic [2:0]  f3s [6] = '{3'b000, 3'b001, 3'b100, 3'b101, 3'b110, 3'b111};
    logic [31:0] a, b;
    logic [2:0]  f3;
    logic        exp;
    for (int i = 0; i < 8; i++) begin
      drive_res(OPC_BRANCH, fv[i], av[i], bv[i], 32'h108, 1'b0);
      cycle();
      checks++; if (diverge_o !== ev[i] || mispredict_o !== ev[i] || res_done_o !== 1'b1) begin errors++; $display("FAIL cond_%0d f3=%b got div=%b mis=%b done=%b exp div=%b", i, fv[i], diverge_o, mispredict_o, res_done_o, ev[i]); end
    end
    for (int i = 0; i < 12; i++) begin
      a = $urandom; b = (i % 4 == 0) ? a : $urandom;
      if (i % 3 == 1) b[31] = ~a[31];
      f3 = f3s[i % 6];
      case (f3)
        3'b000:  exp = a == b;
        3'b001:  exp = a != b;
        3'b100:  exp = $signed(a) < $signed(b);
        3'b101:  exp = $signed(a) >= $signed(b);
        3'b110:  exp = a < b;
        default: exp = a >= b;
      endcase
      drive_res(OPC_BRANCH, f3, a, b, 32'h108, 1'b1);
      cycle();
      checks++; if (diverge_o !== exp || mispredict_o !== !exp) begin errors++; $display("FAIL rand_cond f3=%b a=%h b=%h got div=%b mis=%b exp div=%b", f3, a, b, diverge_o, mispredict_o, exp); end
    end
  endtask

  task automatic test_training();
    stat_clear_i = 1'b1;
    cycle();
    checks++; if ({branch_count_o, mispredict_count_o} !== 8'h00) begin errors++; $display("FAIL train_clear got=%h exp=00", {branch_count_o, mispredict_count_o}); end
    drive_res(OPC_BRANCH, 3'b000, 32'd5, 32'd5, 32'h104, 1'b0);
    cycle();
    checks++; if ({res_done_o, diverge_o, mispredict_o} !== 3'b111) begin errors++; $display("FAIL train_first got=%b exp=111", {res_done_o, diverge_o, mispredict_o}); end
    checks++; if (mispredict_count_o !== 4'd1 || branch_count_o !== 4'd1) begin errors++; $display("FAIL train_counts got=%0d/%0d exp=1/1", branch_count_o, mispredict_count_o); end
    lookup(32'h104);
    cycle();
    checks++; if (pred_taken_o !== 1'b1) begin errors++; $display("FAIL train_pred1 got=%b exp=1", pred_taken_o); end
    for (int i = 0; i < 4; i++) begin
      drive_res(OPC_BRANCH, 3'b000, 32'd5, 32'd5, 32'h104, 1'b1);
      cycle();
    end
    checks++; if (mispredict_o !== 1'b0 || mispredict_count_o !== 4'd1) begin errors++; $display("FAIL train_nomis got=%b/%0d exp=0/1", mispredict_o, mispredict_count_o); end
    drive_res(OPC_BRANCH, 3'b000, 32'd5, 32'd6, 32'h104, 1'b1);
    cycle();
    checks++; if (diverge_o !== 1'b0 || mispredict_o !== 1'b1) begin errors++; $display("FAIL train_nt got=%b%b exp=01", diverge_o, mispredict_o); end
    lookup(32'h104);
    cycle();
    checks++; if (pred_taken_o !== 1'b1) begin errors++; $display("FAIL train_sat_pred got=%b exp=1", pred_taken_o); end
    drive_res(OPC_BRANCH, 3'b001, 32'd5, 32'd5, 32'h104, 1'b1);
    cycle();
    lookup(32'h104);
    cycle();
    checks++; if (pred_taken_o !== 1'b0) begin errors++; $display("FAIL train_weak_nt got=%b exp=0", pred_taken_o); end
    checks++; if (branch_count_o !== 4'd7 || mispredict_count_o !== 4'd3) begin errors++; $display("FAIL train_totals got=%0d/%0d exp=7/3", branch_count_o, mispredict_count_o); end
  endtask

  task automatic test_alias_hazard();
    lookup(32'h100);
    drive_res(OPC_BRANCH, 3'b000, 32'd9, 32'd9, 32'h100, 1'b0);
    cycle();
    checks++; if (pred_taken_o !== 1'b0 || pred_taken_valid_o !== 1'b1 || diverge_o !== 1'b1) begin errors++; $display("FAIL hazard_rbw got=%b%b%b exp=011", pred_taken_o, pred_taken_valid_o, diverge_o); end
    lookup(32'h100);
    cycle();
    checks++; if (pred_taken_o !== 1'b1) begin errors++; $display("FAIL hazard_after got=%b exp=1", pred_taken_o); end
    lookup(32'h200);
    cycle();
    checks++; if (pred_taken_o !== 1'b1) begin errors++; $display("FAIL alias_200 got=%b exp=1", pred_taken_o); end
    cycle();
    checks++; if (pred_taken_o !== 1'b0 || pred_taken_valid_o !== 1'b0) begin errors++; $display("FAIL idle_pred got=%b%b exp=00", pred_taken_o, pred_taken_valid_o); end
  endtask

  task automatic test_non_branch();
    stat_clear_i = 1'b1;
    cycle();
    drive_res(OPC_ARI_RTYPE, 3'b000, 32'd3, 32'd3, 32'h10c, 1'b1);
    cycle();
    checks++; if ({res_done_o, diverge_o, mispredict_o} !== 3'b100) begin errors++; $display("FAIL nonbr_rtype got=%b exp=100", {res_done_o, diverge_o, mispredict_o}); end
    drive_res(OPC_BRANCH, 3'b010, 32'd3, 32'd3, 32'h10c, 1'b1);
    cycle();
    checks++; if ({res_done_o, diverge_o, mispredict_o} !== 3'b100) begin errors++; $display("FAIL nonbr_f3_010 got=%b exp=100", {res_done_o, diverge_o, mispredict_o}); end
    drive_res(OPC_BRANCH, 3'b011, 32'd3, 32'd3, 32'h10c, 1'b1);
    cycle();
    checks++; if ({res_done_o, diverge_o, mispredict_o} !== 3'b100) begin errors++; $display("FAIL nonbr_f3_011 got=%b exp=100", {res_done_o, diverge_o, mispredict_o}); end
    lookup(32'h10c);
    cycle();
    checks++; if (pred_taken_o !== 1'b0 || res_done_o !== 1'b0) begin errors++; $display("FAIL nonbr_table got=%b done=%b exp=0/0", pred_taken_o, res_done_o); end
    checks++; if ({branch_count_o, mispredict_count_o} !== 8'h00) begin errors++; $display("FAIL nonbr_counts got=%h exp=00", {branch_count_o, mispredict_count_o}); end
  endtask

  task automatic test_back_to_back_stats();
    for (int i = 0; i < 20; i++) begin
      drive_res(OPC_BRANCH, 3'b000, 32'd1, 32'd1, 32'h110, 1'b0);
      @(posedge clk);
      #1;
      if (i == 9) begin
        checks++; if (branch_count_o !== 4'd10 || mispredict_count_o !== 4'd10) begin errors++; $display("FAIL stats_mid got=%0d/%0d exp=10/10", branch_count_o, mispredict_count_o); end
      end
    end
    res_valid_i = 1'b0;
    checks++; if (branch_count_o !== 4'd15 || mispredict_count_o !== 4'd15) begin errors++; $display("FAIL stats_sat got=%0d/%0d exp=15/15", branch_count_o, mispredict_count_o); end
    stat_clear_i = 1'b1;
    drive_res(OPC_BRANCH, 3'b000, 32'd1, 32'd1, 32'h110, 1'b0);
    cycle();
    checks++; if (branch_count_o !== 4'd0 || mispredict_count_o !== 4'd0 || res_done_o !== 1'b1) begin errors++; $display("FAIL stats_clear_wins got=%0d/%0d done=%b exp=0/0/1", branch_count_o, mispredict_count_o, res_done_o); end
  endtask

  initial begin
    repeat (3) @(posedge clk);
    #2 rst_n = 1'b1;
    test_reset();
    test_conditions();
    test_training();
    test_alias_hazard();
    test_non_branch();
    test_back_to_back_stats();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
